// File: rtl/dff_shift_seq_pkg.sv
// Shared definitions for the serial shift sequencer: state encoding and
// default sizing constants.
package dff_shift_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2,
        ST_SPARE = 2'd3
    } state_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 4;

    // Smallest counter width able to reach WIDTH-1.
    function automatic int min_cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/dff_shift_reg.sv
// WIDTH-bit D flip-flop chain with parallel load and MSB-first shift.
// Also exposes the word the chain would hold after the next shift.
module dff_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             sin_i,
    output logic             sout_o,
    output logic [WIDTH-1:0] shift_word_o
);

    logic [WIDTH-1:0] chain_q;
    logic [WIDTH-1:0] chain_d;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic shift_src;
            if (gi == 0) begin : g_lsb
                assign shift_src = sin_i;
            end else begin : g_upper
                assign shift_src = chain_q[gi-1];
            end
            // Load wins over shift; otherwise the bit holds.
            assign chain_d[gi]      = load_i  ? din_i[gi] :
                                      shift_i ? shift_src : chain_q[gi];
            assign shift_word_o[gi] = shift_src;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign sout_o = chain_q[WIDTH-1];

endmodule

// File: rtl/dff_shift_seq.sv
// Full-duplex serial shift sequencer: loads a word, shifts it out MSB-first
// while capturing sin, then publishes the captured word with a done strobe.
module dff_shift_seq
    import dff_shift_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] din,
    input  logic             sin,
    output logic             sout,
    output logic             sen,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             load;
    logic             shift;
    logic             chain_msb;
    logic [WIDTH-1:0] shift_word;

    dff_shift_reg #(
        .WIDTH(WIDTH)
    ) u_chain (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load),
        .shift_i     (shift),
        .din_i       (din),
        .sin_i       (sin),
        .sout_o      (chain_msb),
        .shift_word_o(shift_word)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Abort beats the final-bit transition and leaves dout alone.
                if (abort) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    shift = 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        cnt_d   = '0;
                        dout_d  = shift_word;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    assign busy = (state_q == ST_SHIFT);
    assign sen  = busy;
    assign sout = busy & chain_msb;
    assign done = (state_q == ST_DONE);
    assign dout = dout_q;

endmodule

// File: tb/tb_dff_shift_seq.sv
// Randomized and directed transfers checked against a transaction-level model
// of the shifter (bit lists in, bit lists out, fixed cycle timeline).
module tb_dff_shift_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] din = '0;
    logic         sin_drv = 1'b0;
    logic         loop_en = 1'b0;
    logic         sin;
    logic         sout, sen, busy, done;
    logic [W-1:0] dout;

    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0] dout_exp = '0;

    assign sin = loop_en ? sout : sin_drv;

    always #5 clk = ~clk;

    dff_shift_seq #(.WIDTH(W), .CNT_W(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .abort(abort),
        .din  (din),
        .sin  (sin),
        .sout (sout),
        .sen  (sen),
        .busy (busy),
        .done (done),
        .dout (dout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_sen"},  sen,  0);
        check({tag, "_sout"}, sout, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // mode: 0 random sin, 1 loopback, 2 sin held at 1.
    // abort_at: shift index whose closing edge sees abort=1 (-1 for none).
    task automatic xfer(input logic [W-1:0] w, input int mode, input int abort_at,
                        input bit restart);
        logic [W-1:0] cap;
        bit           aborted;
        logic         bit_in;
        cap     = '0;
        aborted = 1'b0;
        loop_en = (mode == 1);
        check("pre_busy", busy, 0);
        start = 1'b1;
        din   = w;
        @(negedge clk);
        start = 1'b0;
        din   = W'($urandom);
        for (int i = 0; i < W; i++) begin
            check("sh_busy", busy, 1);
            check("sh_sen",  sen,  1);
            check("sh_sout", sout, w[W-1-i]);
            check("sh_done", done, 0);
            sin_drv = (mode == 2) ? 1'b1 : 1'($urandom);
            bit_in  = (mode == 1) ? w[W-1-i] : sin_drv;
            cap[W-1-i] = bit_in;
            if (restart && i == 3) begin
                start = 1'b1;
                din   = 8'h3C;
            end
            if (i == abort_at) abort = 1'b1;
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            if (i == abort_at) begin
                aborted = 1'b1;
                break;
            end
        end
        if (aborted) begin
            check_idle_outputs("ab");
            check("ab_dout", dout, dout_exp);
            $display("xfer din=%02h aborted, dout=%02h", w, dout);
        end else begin
            check("dn_done", done, 1);
            check("dn_busy", busy, 0);
            check("dn_sen",  sen,  0);
            check("dn_dout", dout, cap);
            dout_exp = cap;
            @(negedge clk);
            check_idle_outputs("post");
            check("post_dout", dout, dout_exp);
            $display("xfer din=%02h mode=%0d dout=%02h exp=%02h", w, mode, dout, cap);
        end
        loop_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: run exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] bb;
        int           p;
        // Reset state
        #2;
        check_idle_outputs("rst");
        check("rst_dout", dout, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("idle");

        // Directed transfers
        xfer(8'hA5, 1, -1, 1'b0);
        xfer(8'h00, 2, -1, 1'b0);
        xfer(8'h81, 1, -1, 1'b1);
        xfer(8'h5A, 1, -1, 1'b0);
        xfer(8'hF0, 0, 2, 1'b0);
        @(negedge clk);
        check_idle_outputs("ab_idle");

        // Async reset in the middle of a shift
        start = 1'b1;
        din   = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_sout", sout, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("arst");
        check("arst_dout", dout, 0);
        dout_exp = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        xfer(8'h96, 1, -1, 1'b0);

        // Back-to-back with start held high: period W+2
        bb      = 8'hC3;
        loop_en = 1'b1;
        din     = bb;
        start   = 1'b1;
        for (int k = 1; k <= 3 * (W + 2); k++) begin
            @(negedge clk);
            p = (k - 1) % (W + 2);
            if (k == 3 * (W + 2)) start = 1'b0;
            check("bb_sen",  sen,  (p < W) ? 1 : 0);
            check("bb_busy", busy, (p < W) ? 1 : 0);
            check("bb_done", done, (p == W) ? 1 : 0);
            check("bb_sout", sout, (p < W) ? bb[W-1-p] : 1'b0);
            if (p == W) begin
                check("bb_dout", dout, bb);
                $display("b2b done at cycle %0d dout=%02h", k, dout);
            end
        end
        dout_exp = bb;
        loop_en  = 1'b0;
        @(negedge clk);
        check_idle_outputs("bb_end");

        // Randomized transfers
        for (int t = 0; t < 24; t++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check_idle_outputs("gap");
            end
            xfer(W'($urandom), $urandom_range(0, 2),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(0, W-1) : -1,
                 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
